// File: rtl/spi_rx_ctrl_if.sv
// Bus bundle between the SPI receive controller and its user / the SPI slave.
// The controller side uses the master modport.
interface spi_rx_ctrl_if #(
  parameter int unsigned FRAME_BITS = 40
) ();
  logic                  start;
  logic                  miso;
  logic                  sclk;
  logic                  ss;
  logic [FRAME_BITS-1:0] dout;
  logic                  dout_valid;
  logic                  busy;

  modport master (
    input  start, miso,
    output sclk, ss, dout, dout_valid, busy
  );

  modport slave (
    output start, miso,
    input  sclk, ss, dout, dout_valid, busy
  );
endinterface

// File: rtl/spi_rx_ctrl.sv
// SPI master that clocks in one FRAME_BITS-wide frame from miso, MSB first, and
// presents it on dout with a one-cycle dout_valid pulse. All outputs are registered.
module spi_rx_ctrl #(
  parameter int unsigned FRAME_BITS = 40,
  parameter int unsigned CLK_DIV    = 50,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          CONTINUOUS = 1'b0,
  parameter int unsigned GAP_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  spi_rx_ctrl_if.master bus
);
  // One divider serves LEAD/SHIFT/TRAIL half-periods and the GAP count.
  localparam int unsigned CntMax = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned DivW   = $clog2(CntMax);
  localparam int unsigned BitW   = $clog2(FRAME_BITS + 1);

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] GapLast  = DivW'(GAP_CYCLES - 1);
  localparam logic [BitW-1:0] BitsLast = BitW'(FRAME_BITS);

  typedef enum logic [2:0] {StIdle, StLead, StShift, StTrail, StGap} state_e;

  state_e                state_q;
  logic [DivW-1:0]       div_q;
  logic [BitW-1:0]       bit_cnt_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [FRAME_BITS-1:0] dout_q;
  logic                  sclk_q;
  logic                  ss_q;
  logic                  dout_valid_q;
  logic                  busy_q;
  logic                  sample_edge;

  // The upcoming toggle is the sampling edge: leading (leaving CPOL) when CPHA=0,
  // trailing (returning to CPOL) when CPHA=1.
  assign sample_edge = (sclk_q == CPOL) ^ CPHA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      div_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      dout_q       <= '0;
      sclk_q       <= CPOL;
      ss_q         <= 1'b1;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          div_q <= '0;
          if (bus.start || CONTINUOUS) begin
            state_q   <= StLead;
            ss_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        StLead: begin
          if (div_q == DivLast) begin
            div_q   <= '0;
            state_q <= StShift;
            sclk_q  <= ~sclk_q;
            if (sample_edge) begin
              shreg_q   <= {shreg_q[FRAME_BITS-2:0], bus.miso};
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        StShift: begin
          if (div_q == DivLast) begin
            div_q <= '0;
            // Back at idle level with all bits taken: the final half-period is over.
            if (sclk_q == CPOL && bit_cnt_q == BitsLast) begin
              state_q <= StTrail;
            end else begin
              sclk_q <= ~sclk_q;
              if (sample_edge) begin
                shreg_q   <= {shreg_q[FRAME_BITS-2:0], bus.miso};
                bit_cnt_q <= bit_cnt_q + BitW'(1);
              end
            end
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        StTrail: begin
          if (div_q == DivLast) begin
            div_q        <= '0;
            state_q      <= StGap;
            ss_q         <= 1'b1;
            dout_q       <= shreg_q;
            dout_valid_q <= 1'b1;
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        StGap: begin
          if (div_q == GapLast) begin
            div_q   <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.ss         = ss_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_spi_rx_ctrl.sv
// Scoreboard bench for spi_rx_ctrl: three instances (mode 0 / 40 bits, CPOL=1 CPHA=1 / 8 bits,
// continuous / 8 bits), each with a behavioural SPI slave, an expected-frame queue and a monitor.
module tb_spi_rx_ctrl;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_rx_ctrl_if #(.FRAME_BITS(40)) a_if ();
  spi_rx_ctrl_if #(.FRAME_BITS(8))  b_if ();
  spi_rx_ctrl_if #(.FRAME_BITS(8))  c_if ();

  spi_rx_ctrl #(.FRAME_BITS(40), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .CONTINUOUS(1'b0),
                .GAP_CYCLES(4)) u_a (.clk(clk), .rst(rst_a), .bus(a_if));
  spi_rx_ctrl #(.FRAME_BITS(8), .CLK_DIV(3), .CPOL(1'b1), .CPHA(1'b1), .CONTINUOUS(1'b0),
                .GAP_CYCLES(4)) u_b (.clk(clk), .rst(rst_b), .bus(b_if));
  spi_rx_ctrl #(.FRAME_BITS(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .CONTINUOUS(1'b1),
                .GAP_CYCLES(4)) u_c (.clk(clk), .rst(rst_c), .bus(c_if));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- slave models ----------------
  logic [63:0] a_txq[$], b_txq[$], c_txq[$];
  logic [63:0] a_tx, b_tx, c_tx;
  int          a_idx, b_idx, c_idx;

  // Mode 0 slaves: first bit valid on ss fall, next bit after each trailing (falling) edge.
  always @(negedge a_if.ss) begin
    a_tx = '0;
    if (a_txq.size() > 0) a_tx = a_txq.pop_front();
    a_idx = 39;
    a_if.miso = a_tx[a_idx];
  end
  always @(negedge a_if.sclk) if (!a_if.ss && a_idx > 0) begin
    a_idx--;
    a_if.miso = a_tx[a_idx];
  end

  always @(negedge c_if.ss) begin
    c_tx = '0;
    if (c_txq.size() > 0) c_tx = c_txq.pop_front();
    c_idx = 7;
    c_if.miso = c_tx[c_idx];
  end
  always @(negedge c_if.sclk) if (!c_if.ss && c_idx > 0) begin
    c_idx--;
    c_if.miso = c_tx[c_idx];
  end

  // CPOL=1 CPHA=1 slave: drives each bit on the leading (falling) edge.
  always @(negedge b_if.ss) begin
    b_tx = '0;
    if (b_txq.size() > 0) b_tx = b_txq.pop_front();
    b_idx = 7;
  end
  always @(negedge b_if.sclk) if (!b_if.ss && b_idx >= 0) begin
    b_if.miso = b_tx[b_idx];
    b_idx--;
  end

  // ---------------- monitors ----------------
  logic [63:0] a_expq[$], b_expq[$], c_expq[$];
  int a_cyc = 0, a_t0 = 0, a_rises = 0, a_frames = 0;
  int b_cyc = 0, b_t0 = 0, b_rises = 0, b_frames = 0;
  int c_cyc = 0, c_t0 = 0, c_rises = 0, c_frames = 0, c_valids = 0, c_high = 0;
  logic a_pss = 1'b1, a_psclk = 1'b0, a_pdv = 1'b0;
  logic b_pss = 1'b1, b_psclk = 1'b1, b_pdv = 1'b0;
  logic c_pss = 1'b1, c_psclk = 1'b0, c_pdv = 1'b0;
  logic [39:0] a_pdout = '0;
  logic [7:0]  b_pdout = '0, c_pdout = '0;

  always @(negedge clk) begin
    a_cyc++;
    if (!rst_a) begin
      if (a_pss && !a_if.ss) begin a_t0 = a_cyc; a_rises = 0; a_frames++; end
      if (!a_if.ss && !a_psclk && a_if.sclk) a_rises++;
      if (a_if.ss) chk("a_sclk_idle_when_ss_high", a_if.sclk, 0);
      if (!a_pss && a_if.ss) chk("a_ss_rises_only_at_valid", a_if.dout_valid, 1);
      if (a_if.dout !== a_pdout) chk("a_dout_changes_only_at_valid", a_if.dout_valid, 1);
      if (a_if.dout_valid) begin
        chk("a_valid_one_cycle", a_pdv, 0);
        chk("a_latency", a_cyc - a_t0, 164);
        chk("a_sclk_rises", a_rises, 40);
        chk("a_busy_at_valid", a_if.busy, 1);
        if (a_expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_frame: got dout %0h, expected no frame", a_if.dout);
        end else chk("a_dout", a_if.dout, a_expq.pop_front());
      end
    end
    a_pss = a_if.ss; a_psclk = a_if.sclk; a_pdv = a_if.dout_valid; a_pdout = a_if.dout;
  end

  always @(negedge clk) begin
    b_cyc++;
    if (!rst_b) begin
      if (b_pss && !b_if.ss) begin b_t0 = b_cyc; b_rises = 0; b_frames++; end
      if (!b_if.ss && !b_psclk && b_if.sclk) b_rises++;
      if (b_if.ss) chk("b_sclk_idle_when_ss_high", b_if.sclk, 1);
      if (!b_pss && b_if.ss) chk("b_ss_rises_only_at_valid", b_if.dout_valid, 1);
      if (b_if.dout !== b_pdout) chk("b_dout_changes_only_at_valid", b_if.dout_valid, 1);
      if (b_if.dout_valid) begin
        chk("b_valid_one_cycle", b_pdv, 0);
        chk("b_latency", b_cyc - b_t0, 54);
        chk("b_sclk_rises", b_rises, 8);
        if (b_expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_frame: got dout %0h, expected no frame", b_if.dout);
        end else chk("b_dout", b_if.dout, b_expq.pop_front());
      end
    end
    b_pss = b_if.ss; b_psclk = b_if.sclk; b_pdv = b_if.dout_valid; b_pdout = b_if.dout;
  end

  always @(negedge clk) begin
    c_cyc++;
    if (!rst_c) begin
      if (c_if.ss) c_high++;
      if (c_pss && !c_if.ss) begin
        if (c_frames > 0) chk("c_ss_high_between_frames", c_high, 5);
        c_t0 = c_cyc; c_rises = 0; c_frames++; c_high = 0;
      end
      if (!c_if.ss && !c_psclk && c_if.sclk) c_rises++;
      if (c_if.ss) chk("c_sclk_idle_when_ss_high", c_if.sclk, 0);
      if (!c_pss && c_if.ss) chk("c_ss_rises_only_at_valid", c_if.dout_valid, 1);
      if (c_if.dout !== c_pdout) chk("c_dout_changes_only_at_valid", c_if.dout_valid, 1);
      if (c_if.dout_valid) begin
        c_valids++;
        chk("c_latency", c_cyc - c_t0, 36);
        chk("c_sclk_rises", c_rises, 8);
        if (c_expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL c_unexpected_frame: got dout %0h, expected no frame", c_if.dout);
        end else chk("c_dout", c_if.dout, c_expq.pop_front());
      end
    end else c_high = 0;
    c_pss = c_if.ss; c_psclk = c_if.sclk; c_pdv = c_if.dout_valid; c_pdout = c_if.dout;
  end

  // ---------------- stimulus ----------------
  task automatic pulse_a;
    @(negedge clk); a_if.start = 1'b1;
    @(negedge clk); a_if.start = 1'b0;
  endtask

  task automatic pulse_b;
    @(negedge clk); b_if.start = 1'b1;
    @(negedge clk); b_if.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    a_if.start = 1'b0; b_if.start = 1'b0; c_if.start = 1'b0;
    a_if.miso = 1'b0; b_if.miso = 1'b0; c_if.miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_rst_ss", a_if.ss, 1);
    chk("a_rst_sclk", a_if.sclk, 0);
    chk("a_rst_dout", a_if.dout, 0);
    chk("a_rst_valid", a_if.dout_valid, 0);
    chk("a_rst_busy", a_if.busy, 0);
    chk("b_rst_sclk", b_if.sclk, 1);
    chk("b_rst_ss", b_if.ss, 1);
    rst_a = 1'b0; rst_b = 1'b0;

    // Plain mode 0 frame
    a_txq.push_back(64'hA512345678); a_expq.push_back(64'hA512345678);
    pulse_a();
    repeat (200) @(negedge clk);
    chk("a_idle_after_frame", a_if.busy, 0);

    // Abort after 17 samples; the aborted frame must never appear
    a_txq.push_back(64'h123456789A);
    pulse_a();
    repeat (17) @(posedge a_if.sclk);
    #1 rst_a = 1'b1;
    #1;
    chk("a_abort_ss", a_if.ss, 1);
    chk("a_abort_dout", a_if.dout, 0);
    chk("a_abort_sclk", a_if.sclk, 0);
    chk("a_abort_busy", a_if.busy, 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    a_txq.push_back(64'hFFFFFFFFFF); a_expq.push_back(64'hFFFFFFFFFF);
    pulse_a();
    repeat (200) @(negedge clk);

    // start held through a frame and dropped just after dout_valid: one frame only
    f0 = a_frames;
    a_txq.push_back(64'h00FF00FF00); a_expq.push_back(64'h00FF00FF00);
    @(negedge clk); a_if.start = 1'b1;
    for (int n = 0; n < 400 && !a_if.dout_valid; n++) @(negedge clk);
    chk("a_held_valid_seen", a_if.dout_valid, 1);
    @(negedge clk); a_if.start = 1'b0;
    repeat (200) @(negedge clk);
    chk("a_held_one_frame", a_frames - f0, 1);

    // start pulsed exactly in the dout_valid cycle: ignored, not queued
    f0 = a_frames;
    a_txq.push_back(64'h5A5A5A5A5A); a_expq.push_back(64'h5A5A5A5A5A);
    pulse_a();
    for (int n = 0; n < 400 && !a_if.dout_valid; n++) @(negedge clk);
    chk("a_pulse_valid_seen", a_if.dout_valid, 1);
    a_if.start = 1'b1;
    @(negedge clk); a_if.start = 1'b0;
    repeat (200) @(negedge clk);
    chk("a_pulse_one_frame", a_frames - f0, 1);
    chk("a_pulse_idle", a_if.busy, 0);

    // CPOL=1 CPHA=1
    b_txq.push_back(64'h3C); b_expq.push_back(64'h3C);
    pulse_b();
    repeat (100) @(negedge clk);
    b_txq.push_back(64'hA5); b_expq.push_back(64'hA5);
    pulse_b();
    repeat (100) @(negedge clk);
    chk("b_frames", b_frames, 2);
    chk("b_idle_after_frames", b_if.busy, 0);

    // Continuous mode: three frames, then stop it in the gap before a fourth
    for (int i = 1; i <= 3; i++) begin
      c_txq.push_back(64'(i)); c_expq.push_back(64'(i));
    end
    @(negedge clk); rst_c = 1'b0;
    for (int n = 0; n < 500 && c_valids < 3; n++) @(negedge clk);
    rst_c = 1'b1;
    chk("c_valid_count", c_valids, 3);
    repeat (5) @(negedge clk);
    chk("c_frames", c_frames, 3);

    chk("a_queue_drained", a_expq.size(), 0);
    chk("b_queue_drained", b_expq.size(), 0);
    chk("c_queue_drained", c_expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
